// File: rtl/llabs_pkg.sv
// Shared constants and types for the llabs VGA board renderer:
// raster timing, board geometry, cell/status codes and the colour palette.
package llabs_pkg;

  // Horizontal raster timing, in pixel clocks.
  localparam int H_VISIBLE    = 640;
  localparam int H_FRONT      = 16;
  localparam int H_SYNC       = 96;
  localparam int H_BACK       = 48;
  localparam int H_TOTAL      = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int H_SYNC_START = H_VISIBLE + H_FRONT;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;

  // Vertical raster timing, in lines.
  localparam int V_VISIBLE    = 480;
  localparam int V_FRONT      = 10;
  localparam int V_SYNC       = 2;
  localparam int V_BACK       = 33;
  localparam int V_TOTAL      = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int V_SYNC_START = V_VISIBLE + V_FRONT;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;

  // Width of the raster counters (both fit 0..799).
  localparam int CNT_W = 10;

  // Board geometry defaults: 16x16 cells of 16x16 pixels.
  localparam int BOARD_X0_DEF = 192;
  localparam int BOARD_Y0_DEF = 112;
  localparam int CELL_PX_DEF  = 16;
  localparam int BOARD_CELLS  = 16;
  localparam int BOARD_BITS   = BOARD_CELLS * BOARD_CELLS * 2;

  // Stone disc: (2dx-15)^2 + (2dy-15)^2 <= STONE_R2 for the default cell size.
  localparam int STONE_R2 = 196;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    BLACK = 2'b01,
    WHITE = 2'b10,
    RSVD  = 2'b11
  } cell_e;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    P1_TURN = 2'b01,
    P2_TURN = 2'b10,
    OVER    = 2'b11
  } status_e;

  typedef struct packed {
    logic [9:0] r;
    logic [9:0] g;
    logic [9:0] b;
  } rgb_t;

  localparam rgb_t COL_BLANK   = '{r: 10'h000, g: 10'h000, b: 10'h000};
  localparam rgb_t COL_CURSOR  = '{r: 10'h3FF, g: 10'h000, b: 10'h000};
  localparam rgb_t COL_BLACK   = '{r: 10'h040, g: 10'h040, b: 10'h040};
  localparam rgb_t COL_WHITE   = '{r: 10'h3FF, g: 10'h3FF, b: 10'h3FF};
  localparam rgb_t COL_GRID    = '{r: 10'h000, g: 10'h000, b: 10'h000};
  localparam rgb_t COL_WOOD    = '{r: 10'h320, g: 10'h260, b: 10'h0C0};
  localparam rgb_t COL_ST_IDLE = '{r: 10'h100, g: 10'h100, b: 10'h100};
  localparam rgb_t COL_ST_P1   = '{r: 10'h000, g: 10'h000, b: 10'h200};
  localparam rgb_t COL_ST_P2   = '{r: 10'h280, g: 10'h280, b: 10'h280};
  localparam rgb_t COL_ST_OVER = '{r: 10'h000, g: 10'h300, b: 10'h000};

  // Bit offset of cell (x,y) inside the packed board vector: x*2 + y*32.
  function automatic logic [8:0] CO_TO_OFFSET(input logic [3:0] x, input logic [3:0] y);
    return {y, 5'b0_0000} + {4'b0000, x, 1'b0};
  endfunction

endpackage

// File: rtl/llabs_vga_timing.sv
// 640x480@60 raster generator: divides the system clock by two for the
// pixel clock and runs the h/v counters on the pixel-enable edge.
module llabs_vga_timing
  import llabs_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_n_i,
  output logic             pe_o,
  output logic             pix_clk_o,
  output logic [CNT_W-1:0] h_o,
  output logic [CNT_W-1:0] v_o,
  output logic             hsync_o,
  output logic             vsync_o,
  output logic             active_o,
  output logic             frame_start_o
);

  logic             toggle_q, toggle_d;
  logic [CNT_W-1:0] h_q, h_d;
  logic [CNT_W-1:0] v_q, v_d;
  logic             h_last, v_last;

  assign h_last = (h_q == CNT_W'(H_TOTAL - 1));
  assign v_last = (v_q == CNT_W'(V_TOTAL - 1));

  // Next state: toggle every clock; advance the raster only when the toggle is high.
  always_comb begin
    toggle_d = ~toggle_q;
    h_d      = h_q;
    v_d      = v_q;
    if (toggle_q) begin
      if (h_last) begin
        h_d = '0;
        v_d = v_last ? '0 : v_q + 1'b1;
      end else begin
        h_d = h_q + 1'b1;
      end
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      toggle_q <= 1'b0;
      h_q      <= '0;
      v_q      <= '0;
    end else begin
      toggle_q <= toggle_d;
      h_q      <= h_d;
      v_q      <= v_d;
    end
  end

  // The pixel clock falls on exactly the edges where the counters move.
  assign pe_o          = toggle_q;
  assign pix_clk_o     = toggle_q;
  assign h_o           = h_q;
  assign v_o           = v_q;
  assign hsync_o       = (h_q >= CNT_W'(H_SYNC_START)) && (h_q < CNT_W'(H_SYNC_END));
  assign vsync_o       = (v_q >= CNT_W'(V_SYNC_START)) && (v_q < CNT_W'(V_SYNC_END));
  assign active_o      = (h_q < CNT_W'(H_VISIBLE)) && (v_q < CNT_W'(V_VISIBLE));
  // Last pixel of the frame on a moving edge: the safe point to sample new inputs.
  assign frame_start_o = toggle_q && h_last && v_last;

endmodule

// File: rtl/llabs.sv
// Direct-drive VGA renderer for the 16x16 five-in-a-row board. Each pixel is
// computed on the fly from a per-frame snapshot of board, status and cursor.
module llabs
  import llabs_pkg::*;
#(
  parameter int BOARD_X0 = BOARD_X0_DEF,
  parameter int BOARD_Y0 = BOARD_Y0_DEF,
  parameter int CELL_PX  = CELL_PX_DEF
) (
  input  logic                  Clck,
  input  logic                  Reset,
  input  logic [BOARD_BITS-1:0] board,
  input  logic [1:0]            gaming_status,
  input  logic [3:0]            pointer_loc_x,
  input  logic [3:0]            pointer_loc_y,
  output logic                  VGA_CLK,
  output logic                  VGA_HS,
  output logic                  VGA_VS,
  output logic                  VGA_BLANK_N,
  output logic                  VGA_SYNC_N,
  output logic [9:0]            VGA_R,
  output logic [9:0]            VGA_G,
  output logic [9:0]            VGA_B
);

  localparam int CELL_SH   = $clog2(CELL_PX);
  localparam int OFF_W     = CELL_SH + 4;
  localparam int BOARD_PX  = CELL_PX * BOARD_CELLS;
  localparam int SQ_W      = 2 * CELL_SH;
  // Stone radius scales with the cell size (196 for 16-pixel cells).
  localparam int STONE_LIM = STONE_R2 * CELL_PX * CELL_PX / (CELL_PX_DEF * CELL_PX_DEF);

  // Raster timing
  logic             pe, pix_clk, hsync, vsync, active, frame_start;
  logic [CNT_W-1:0] h, v;

  llabs_vga_timing u_timing (
    .clk_i        (Clck),
    .rst_n_i      (Reset),
    .pe_o         (pe),
    .pix_clk_o    (pix_clk),
    .h_o          (h),
    .v_o          (v),
    .hsync_o      (hsync),
    .vsync_o      (vsync),
    .active_o     (active),
    .frame_start_o(frame_start)
  );

  // Per-frame input snapshot
  logic [BOARD_BITS-1:0] board_q;
  status_e               status_q;
  logic [3:0]            ptr_x_q, ptr_y_q;

  // Registered outputs
  logic hs_q, vs_q, blank_n_q;
  logic hs_d, vs_d;
  rgb_t pix_q, pix_d;

  // Board-relative geometry
  logic               in_board;
  logic [OFF_W-1:0]   ox, oy;
  logic [3:0]         cx, cy;
  logic [CELL_SH-1:0] dx, dy;
  cell_e              cell_code;
  logic               cursor_hit, stone_hit, grid_hit;

  assign in_board = (h >= CNT_W'(BOARD_X0)) && (h < CNT_W'(BOARD_X0 + BOARD_PX)) &&
                    (v >= CNT_W'(BOARD_Y0)) && (v < CNT_W'(BOARD_Y0 + BOARD_PX));

  assign ox = OFF_W'(h - CNT_W'(BOARD_X0));
  assign oy = OFF_W'(v - CNT_W'(BOARD_Y0));
  assign cx = ox[OFF_W-1 -: 4];
  assign cy = oy[OFF_W-1 -: 4];
  assign dx = ox[CELL_SH-1:0];
  assign dy = oy[CELL_SH-1:0];

  assign cell_code = cell_e'(board_q[CO_TO_OFFSET(cx, cy) +: 2]);

  // Distance from the cell centre per axis: |2d - (CELL_PX-1)|, always odd,
  // so the disc is symmetric about the middle of the cell.
  logic [CELL_SH-1:0] d_ax   [2];
  logic [CELL_SH-1:0] mag_ax [2];
  logic [SQ_W-1:0]    sq_ax  [2];

  assign d_ax[0] = dx;
  assign d_ax[1] = dy;

  for (genvar gi = 0; gi < 2; gi++) begin : g_axis
    logic [CELL_SH:0] twice;
    assign twice      = {d_ax[gi], 1'b0};
    assign mag_ax[gi] = d_ax[gi][CELL_SH-1]
                      ? CELL_SH'(twice - (CELL_SH+1)'(CELL_PX - 1))
                      : CELL_SH'((CELL_SH+1)'(CELL_PX - 1) - twice);
    assign sq_ax[gi]  = SQ_W'(mag_ax[gi]) * SQ_W'(mag_ax[gi]);
  end

  assign stone_hit = ((SQ_W+1)'(sq_ax[0]) + (SQ_W+1)'(sq_ax[1])) <= (SQ_W+1)'(STONE_LIM);

  // Cursor ring sits one pixel inside the grid lines of the selected cell.
  assign cursor_hit = (cx == ptr_x_q) && (cy == ptr_y_q) &&
                      ((dx == CELL_SH'(1)) || (dx == CELL_SH'(CELL_PX - 2)) ||
                       (dy == CELL_SH'(1)) || (dy == CELL_SH'(CELL_PX - 2)));

  // Each cell draws its own left/top line; the far edge closes the grid.
  assign grid_hit = (dx == '0) || (dy == '0) ||
                    (h == CNT_W'(BOARD_X0 + BOARD_PX - 1)) ||
                    (v == CNT_W'(BOARD_Y0 + BOARD_PX - 1));

  assign hs_d = ~hsync;
  assign vs_d = ~vsync;

  // Pixel colour for the current raster position, highest priority first.
  always_comb begin
    pix_d = COL_BLANK;
    if (active) begin
      if (in_board) begin
        if (cursor_hit) begin
          pix_d = COL_CURSOR;
        end else if (stone_hit && (cell_code == BLACK)) begin
          pix_d = COL_BLACK;
        end else if (stone_hit && (cell_code == WHITE)) begin
          pix_d = COL_WHITE;
        end else if (grid_hit) begin
          pix_d = COL_GRID;
        end else begin
          pix_d = COL_WOOD;
        end
      end else begin
        case (status_q)
          IDLE:    pix_d = COL_ST_IDLE;
          P1_TURN: pix_d = COL_ST_P1;
          P2_TURN: pix_d = COL_ST_P2;
          OVER:    pix_d = COL_ST_OVER;
          default: pix_d = COL_ST_IDLE;
        endcase
      end
    end
  end

  // Snapshot the controller's state once per frame so a frame never tears.
  always_ff @(posedge Clck) begin
    if (!Reset) begin
      board_q  <= '0;
      status_q <= IDLE;
      ptr_x_q  <= '0;
      ptr_y_q  <= '0;
    end else if (frame_start) begin
      board_q  <= board;
      status_q <= status_e'(gaming_status);
      ptr_x_q  <= pointer_loc_x;
      ptr_y_q  <= pointer_loc_y;
    end
  end

  // Register sync, blank and colour together so they stay pixel-aligned.
  always_ff @(posedge Clck) begin
    if (!Reset) begin
      hs_q      <= 1'b1;
      vs_q      <= 1'b1;
      blank_n_q <= 1'b0;
      pix_q     <= COL_BLANK;
    end else if (pe) begin
      hs_q      <= hs_d;
      vs_q      <= vs_d;
      blank_n_q <= active;
      pix_q     <= pix_d;
    end
  end

  assign VGA_CLK     = pix_clk;
  assign VGA_HS      = hs_q;
  assign VGA_VS      = vs_q;
  assign VGA_BLANK_N = blank_n_q;
  assign VGA_SYNC_N  = 1'b0;
  assign VGA_R       = pix_q.r;
  assign VGA_G       = pix_q.g;
  assign VGA_B       = pix_q.b;

endmodule

// File: tb/tb_llabs.sv
// Bench for llabs: a pixel-index model of the raster and colour rules,
// compared against the DUT on every system clock, plus literal pixel checks.
`timescale 1ns/1ps
module tb_llabs;

  localparam int FRAME = 800 * 525;

  logic         Clck = 1'b0;
  logic         Reset = 1'b0;
  logic [511:0] board = '0;
  logic [1:0]   gaming_status = 2'b00;
  logic [3:0]   pointer_loc_x = 4'd0;
  logic [3:0]   pointer_loc_y = 4'd0;
  logic         VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N;
  logic [9:0]   VGA_R, VGA_G, VGA_B;

  always #10 Clck = ~Clck;

  llabs dut (
    .Clck         (Clck),
    .Reset        (Reset),
    .board        (board),
    .gaming_status(gaming_status),
    .pointer_loc_x(pointer_loc_x),
    .pointer_loc_y(pointer_loc_y),
    .VGA_CLK      (VGA_CLK),
    .VGA_HS       (VGA_HS),
    .VGA_VS       (VGA_VS),
    .VGA_BLANK_N  (VGA_BLANK_N),
    .VGA_SYNC_N   (VGA_SYNC_N),
    .VGA_R        (VGA_R),
    .VGA_G        (VGA_G),
    .VGA_B        (VGA_B)
  );

  int chk_cnt  = 0;
  int pass_cnt = 0;
  bit abort    = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    chk_cnt++;
    if (act === expv) pass_cnt++;
    else begin
      $display("FAIL %s actual=%0h expected=%0h", name, act, expv);
      if (chk_cnt - pass_cnt >= 40) abort = 1'b1;
    end
  endtask

  // Colour of screen pixel (x,y) straight from the drawing rules.
  function automatic logic [29:0] model_colour(input int x, input int y, input logic [511:0] b,
                                               input logic [1:0] st, input int cpx, input int cpy);
    int ox, oy, cx, cy, dx, dy, ux, uy;
    logic [1:0] code;
    if (x >= 640 || y >= 480) return 30'h0;
    if (x < 192 || x > 447 || y < 112 || y > 367) begin
      case (st)
        2'b00:   return {10'h100, 10'h100, 10'h100};
        2'b01:   return {10'h000, 10'h000, 10'h200};
        2'b10:   return {10'h280, 10'h280, 10'h280};
        default: return {10'h000, 10'h300, 10'h000};
      endcase
    end
    ox = x - 192; oy = y - 112;
    cx = ox / 16; cy = oy / 16; dx = ox % 16; dy = oy % 16;
    code = b[cx*2 + cy*32 +: 2];
    if (cx == cpx && cy == cpy && (dx == 1 || dx == 14 || dy == 1 || dy == 14))
      return {10'h3FF, 10'h000, 10'h000};
    ux = 2*dx - 15; uy = 2*dy - 15;
    if (ux*ux + uy*uy <= 196) begin
      if (code == 2'b01) return {10'h040, 10'h040, 10'h040};
      if (code == 2'b10) return {10'h3FF, 10'h3FF, 10'h3FF};
    end
    if (dx == 0 || dy == 0 || x == 447 || y == 367) return 30'h0;
    return {10'h320, 10'h260, 10'h0C0};
  endfunction

  // Model state: c = system clocks since reset release, k = pixel clocks.
  int c = 0, k = 0, exp_p = 0, exp_hp = 0, exp_vp = 0, exp_fr = 0;
  bit pe_edge = 1'b0;
  logic exp_clk, exp_hs, exp_vs, exp_blank;
  logic [29:0] exp_rgb;
  logic [511:0] cfg_board = '0;
  logic [1:0]   cfg_status = 2'b00;
  int           cfg_px = 0, cfg_py = 0;

  initial begin
    forever begin
      @(posedge Clck);
      if (Reset !== 1'b1) begin
        c = 0; k = 0; pe_edge = 1'b0;
        cfg_board = '0; cfg_status = 2'b00; cfg_px = 0; cfg_py = 0;
        exp_clk = 1'b0; exp_hs = 1'b1; exp_vs = 1'b1; exp_blank = 1'b0; exp_rgb = '0;
      end else begin
        c = c + 1;
        exp_clk = c[0];
        pe_edge = (c % 2 == 0);
        if (pe_edge) begin
          k = c / 2;
          exp_p  = k - 1;
          exp_fr = exp_p / FRAME;
          exp_hp = exp_p % 800;
          exp_vp = (exp_p / 800) % 525;
          exp_hs = !(exp_hp >= 656 && exp_hp < 752);
          exp_vs = !(exp_vp >= 490 && exp_vp < 492);
          exp_blank = (exp_hp < 640 && exp_vp < 480);
          exp_rgb = model_colour(exp_hp, exp_vp, cfg_board, cfg_status, cfg_px, cfg_py);
          if (k % FRAME == 0) begin
            cfg_board = board; cfg_status = gaming_status;
            cfg_px = pointer_loc_x; cfg_py = pointer_loc_y;
          end
        end
      end
    end
  end

  // Literal pixel expectations: frame, x, y, {R,G,B}.
  typedef struct {
    int f; int x; int y; logic [29:0] rgb;
  } lit_t;
  lit_t lits[$];
  bit   lit_hit[32];

  int hs_low = 0, vs_low = 0, blank_hi = 0, first_hs_k = -1;
  bit counts_done = 1'b0;

  // Compare process: every system clock, away from the active edge.
  initial begin
    forever begin
      @(negedge Clck);
      check($sformatf("cycle c=%0d k=%0d {clk,hs,vs,blank,sync,rgb}", c, k),
            {29'd0, VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N, VGA_R, VGA_G, VGA_B},
            {29'd0, exp_clk, exp_hs, exp_vs, exp_blank, 1'b0, exp_rgb});
      if (Reset === 1'b1 && pe_edge) begin
        if (!counts_done) begin
          if (VGA_HS === 1'b0) begin
            hs_low++;
            if (first_hs_k < 0) first_hs_k = k;
          end
          if (VGA_VS === 1'b0) vs_low++;
          if (VGA_BLANK_N === 1'b1) blank_hi++;
          if (exp_p == FRAME - 1) begin
            counts_done = 1'b1;
            check("first_hs_low_pixel", first_hs_k, 657);
            check("hs_low_per_frame", hs_low, 96 * 525);
            check("vs_low_per_frame", vs_low, 2 * 800);
            check("blank_n_high_per_frame", blank_hi, 640 * 480);
          end
        end
        foreach (lits[i]) begin
          if (lits[i].f == exp_fr && lits[i].x == exp_hp && lits[i].y == exp_vp) begin
            lit_hit[i] = 1'b1;
            check($sformatf("lit_f%0d_(%0d,%0d)_rgb", lits[i].f, lits[i].x, lits[i].y),
                  {34'd0, VGA_R, VGA_G, VGA_B}, {34'd0, lits[i].rgb});
          end
        end
      end
    end
  end

  task automatic finish_run();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  endtask

  task automatic wait_k(input int target);
    int guard = 0;
    while (k < target && !abort && guard < 2000000) begin
      @(negedge Clck);
      guard++;
    end
    if (guard >= 2000000) begin
      chk_cnt++;
      $display("FAIL wait_k timeout actual=%0d required=%0d", k, target);
      abort = 1'b1;
    end
    if (abort) finish_run();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_vga_clk"}, VGA_CLK, 1'b0);
    check({tag, "_hs"}, VGA_HS, 1'b1);
    check({tag, "_vs"}, VGA_VS, 1'b1);
    check({tag, "_blank_n"}, VGA_BLANK_N, 1'b0);
    check({tag, "_sync_n"}, VGA_SYNC_N, 1'b0);
    check({tag, "_rgb"}, {VGA_R, VGA_G, VGA_B}, 30'h0);
  endtask

  initial begin
    // Frame 0: latched state is all zero (empty board, idle, cursor at 0,0).
    lits.push_back('{0, 193, 120, {10'h3FF, 10'h000, 10'h000}});
    lits.push_back('{0, 200, 120, {10'h320, 10'h260, 10'h0C0}});
    lits.push_back('{0, 100, 100, {10'h100, 10'h100, 10'h100}});
    lits.push_back('{0, 248, 200, {10'h320, 10'h260, 10'h0C0}});
    lits.push_back('{0, 100, 300, {10'h100, 10'h100, 10'h100}});
    // Frame 1: board all 1s, (3,5)=black, (4,5)=white, status 10, cursor (4,6).
    lits.push_back('{1, 200, 120, {10'h320, 10'h260, 10'h0C0}});
    lits.push_back('{1, 100, 100, {10'h280, 10'h280, 10'h280}});
    lits.push_back('{1, 257, 216, {10'h3FF, 10'h000, 10'h000}});
    lits.push_back('{1, 248, 200, {10'h040, 10'h040, 10'h040}});
    lits.push_back('{1, 264, 200, {10'h3FF, 10'h3FF, 10'h3FF}});
    lits.push_back('{1, 241, 200, {10'h040, 10'h040, 10'h040}});
    lits.push_back('{1, 242, 194, {10'h320, 10'h260, 10'h0C0}});
    lits.push_back('{1, 192, 150, {10'h000, 10'h000, 10'h000}});
    lits.push_back('{1, 447, 200, {10'h000, 10'h000, 10'h000}});
    lits.push_back('{1, 640, 10,  {10'h000, 10'h000, 10'h000}});
    lits.push_back('{1, 100, 300, {10'h280, 10'h280, 10'h280}});
    // Frame 2: status 11 latched.
    lits.push_back('{2, 0, 0, {10'h000, 10'h300, 10'h000}});
    lits.push_back('{2, 5, 0, {10'h000, 10'h300, 10'h000}});

    Reset = 1'b0;
    repeat (4) @(negedge Clck);
    check_reset_outputs("reset");
    Reset = 1'b1;

    // Change inputs at row 200 of frame 0; they must only show in frame 1.
    wait_k(200 * 800);
    board = '1;
    board[166 +: 2] = 2'b01;
    board[168 +: 2] = 2'b10;
    gaming_status = 2'b10;
    pointer_loc_x = 4'd4;
    pointer_loc_y = 4'd6;

    // Change status at row 250 of frame 1; it must only show in frame 2.
    wait_k(FRAME + 250 * 800);
    gaming_status = 2'b11;

    wait_k(2 * FRAME + 10);

    // Mid-frame reset returns every output on the next edge.
    Reset = 1'b0;
    @(negedge Clck);
    check_reset_outputs("midreset");
    @(negedge Clck);
    Reset = 1'b1;
    repeat (20) @(negedge Clck);

    foreach (lits[i])
      check($sformatf("lit_reached_f%0d_(%0d,%0d)", lits[i].f, lits[i].x, lits[i].y),
            lit_hit[i], 1'b1);
    finish_run();
  end

endmodule

// File: doc/llabs.md
Name: llabs

Overview:
- Direct-drive VGA renderer for the FiveSons 16x16 five-in-a-row game. It has no frame buffer.
- It generates 640x480@60 timing from the 50 MHz system clock. Each pixel's colour is computed from the packed board state, the game status and the cursor position.
- It sits between the game controller (which owns board/status/pointer) and the VGA DAC pins.

Parameters:
- BOARD_X0, 192, left pixel column of board area.
- BOARD_Y0, 112, top pixel row of board area.
- CELL_PX, 16, cell size in pixels (power of two; the cell index is the offset bits [7:4]).

Ports:
- Clck, input, 1, 50 MHz system clock.
- Reset, input, 1, synchronous active-low reset.
- board, input, 512, packed 2-bit cells; cell (x,y) occupies bits [x*2 + y*32 +: 2].
- gaming_status, input, 2, game state.
- pointer_loc_x, input, 4, cursor column 0..15.
- pointer_loc_y, input, 4, cursor row 0..15.
- VGA_CLK, output, 1, 25 MHz pixel clock (Clck/2).
- VGA_HS, output, 1, horizontal sync, active low.
- VGA_VS, output, 1, vertical sync, active low.
- VGA_BLANK_N, output, 1, high during the active area.
- VGA_SYNC_N, output, 1, constant 0.
- VGA_R, output, 10, red.
- VGA_G, output, 10, green.
- VGA_B, output, 10, blue.

Behaviour:
- Clocking: one clock (Clck). Reset is synchronous and active-low.
  - A toggle register drives VGA_CLK.
  - The pixel enable pe = toggle==1. Counters and outputs update on the Clck edge where pe=1, i.e. on the VGA_CLK falling transition.
- Reset values: VGA_CLK=0, h=0, v=0, HS=1, VS=1, BLANK_N=0, RGB=0, latched inputs=0. SYNC_N is always 0.
- Reset asserted mid-frame: everything returns to the reset values on the next Clck edge.
- Horizontal counter h, 0..799, wraps to 0:
  - active 0-639; front porch 640-655; sync 656-751 (HS low); back porch 752-799.
- Vertical counter v, 0..524: increments when h wraps and wraps to 0 after 524.
  - active 0-479; front porch 480-489; sync 490-491 (VS low); back porch 492-524.
- Output latency: HS, VS, BLANK_N and RGB are registered from the current (h,v), so all are mutually aligned with 1 pixel latency.
- Input latching:
  - board, gaming_status and the pointer are captured on the pe edge where h=799 and v=524.
  - Changes made mid-frame appear only in the next frame, so there is no tearing.
- Geometry:
  - Board area is x in [192,447], y in [112,367].
  - ox = h-192 and oy = v-112 (8-bit).
  - Cell index: cx=ox[7:4], cy=oy[7:4].
  - Offset within cell: dx=ox[3:0], dy=oy[3:0].
- Cell codes:
  - 00 = empty.
  - 01 = black stone.
  - 10 = white stone.
  - 11 = reserved, drawn as empty.
- Stone shape: ux=2*dx-15, uy=2*dy-15 (signed, odd values). The stone covers ux^2+uy^2 <= 196.
- Colour priority inside the board, highest first:
  1. Cursor: cell == pointer and (dx in {1,14} or dy in {1,14}) -> R=3FF G=000 B=000.
  2. Stone: black -> 040/040/040; white -> 3FF/3FF/3FF.
  3. Grid: dx==0 or dy==0, or h==447 or v==367 -> 000/000/000.
  4. Otherwise empty wood -> 320/260/0C0.
- Outside the board but in the active area, colour follows gaming_status:
  - 00 idle -> 100/100/100.
  - 01 black to move -> 000/000/200.
  - 10 white to move -> 280/280/280.
  - 11 game over -> 000/300/000.
- Blanking (outside the active area): RGB=0.

Decomposition:
- Package llabs_pkg holds:
  - H/V timing constants (visible, front porch, sync, back porch, total);
  - geometry constants;
  - cell-code enum (EMPTY, BLACK, WHITE, RSVD);
  - status enum (IDLE, P1_TURN, P2_TURN, OVER);
  - colour constants;
  - the CO_TO_OFFSET(x,y)=x*2+y*32 helper.
- One sub-module, llabs_vga_timing: counters, pe, HS/VS/active flags and frame-start strobe.
- Pixel colour logic stays in llabs.

Test Plan:
- Reset: hold Reset=0 for 4 Clck -> VGA_CLK=0, HS=VS=1, BLANK_N=0, RGB=0, SYNC_N=0. Release -> VGA_CLK toggles every Clck.
- Timing: count pixels after reset release.
  - HS is low for exactly 96 of every 800 pixels, starting at pixel 656 (+1 latency).
  - VS is low for 2 of 525 lines.
  - BLANK_N is high for 640 pixels x 480 lines.
- Background colours: board all 1s, status 10, pointer (4,6).
  - Pixel (200,120) -> 320/260/0C0.
  - Pixel (100,100) -> 280/280/280.
  - Pixel (257,216) -> 3FF/000/000 (cursor).
- Stones: set bits [166+:2]=01 (cell 3,5) -> pixel (248,200) = 040/040/040. Set 10 -> 3FF/3FF/3FF. Set 11 -> empty colour.
- Grid: pixel (192,150) with an empty cell -> 000/000/000.
- Status: setting 11 gives 000/300/000 outside the board.
- Latching: change the board at v=200 -> the current frame is unchanged; the next frame shows the change.
